// File: rtl/flag_ctrl_if.sv
// Bundle of EX-stage flag sources, ID-stage branch request and branch/flag results.
interface flag_ctrl_if;
    logic       ex_valid;
    logic [3:0] ex_opcode;
    logic       alu_z;
    logic       alu_n;
    logic       alu_v;
    logic       stall;
    logic       flush;
    logic       br_valid;
    logic [2:0] br_ccc;
    logic       br_taken;
    logic       hazard;
    logic [2:0] flags;

    modport master (
        output ex_valid, ex_opcode, alu_z, alu_n, alu_v, stall, flush, br_valid, br_ccc,
        input  br_taken, hazard, flags
    );

    modport slave (
        input  ex_valid, ex_opcode, alu_z, alu_n, alu_v, stall, flush, br_valid, br_ccc,
        output br_taken, hazard, flags
    );
endinterface

// File: rtl/flag_ctrl.sv
// Architectural {Z,V,N} flag register plus conditional-branch evaluation, resolving
// the EX->ID flag hazard either by a one-cycle stall or by forwarding ALU flags.
module flag_ctrl #(
    parameter bit FORWARD = 1'b0
) (
    input logic        clk,
    input logic        rst_n,
    flag_ctrl_if.slave bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    logic [2:0] flag_q;  // {Z,V,N}
    logic       sets_all;
    logic       sets_z;
    logic       fw;
    logic       pending;

    function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] f);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (ccc)
            3'b000:  cond_met = ~z;
            3'b001:  cond_met = z;
            3'b010:  cond_met = ~z & ~n;
            3'b011:  cond_met = n;
            3'b100:  cond_met = z | ~n;
            3'b101:  cond_met = z | n;
            3'b110:  cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

    assign sets_all = (bus.ex_opcode == 4'b0000) || (bus.ex_opcode == 4'b0001);
    assign sets_z   = (bus.ex_opcode == 4'b0010) || (bus.ex_opcode == 4'b0100) ||
                      (bus.ex_opcode == 4'b0101) || (bus.ex_opcode == 4'b0110);
    assign fw       = bus.ex_valid & ~bus.stall & ~bus.flush;
    assign pending  = bus.ex_valid & ~bus.flush & (sets_all | sets_z);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 3'b000;
        end else if (fw && sets_all) begin
            flag_q <= {bus.alu_z, bus.alu_v, bus.alu_n};
        end else if (fw && sets_z) begin
            flag_q[2] <= bus.alu_z;
        end
    end

    assign bus.flags = flag_q;

    generate
        if (FORWARD) begin : g_forward
            logic [2:0] fwd_flags;

            // Overlay only the bits the in-flight op will write; the rest come from the register.
            assign fwd_flags[2] = pending ? bus.alu_z : flag_q[2];
            assign fwd_flags[1] = (pending && sets_all) ? bus.alu_v : flag_q[1];
            assign fwd_flags[0] = (pending && sets_all) ? bus.alu_n : flag_q[0];

            assign bus.hazard   = 1'b0;
            assign bus.br_taken = bus.br_valid & cond_met(bus.br_ccc, fwd_flags);
        end else begin : g_stall
            state_t state_q;
            state_t state_d;
            logic   hazard_c;
            logic   taken_c;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= ST_IDLE;
                end else begin
                    state_q <= state_d;
                end
            end

            // NOTE: every output of this block is defaulted first so no path can infer a latch.
            always_comb begin
                state_d  = state_q;
                hazard_c = 1'b0;
                taken_c  = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (bus.br_valid) begin
                            if (pending && !bus.stall) begin
                                hazard_c = 1'b1;
                                state_d  = ST_WAIT;
                            end else begin
                                taken_c = cond_met(bus.br_ccc, flag_q);
                            end
                        end
                    end
                    ST_WAIT: begin
                        // Flags now hold the producer's result; always release after one cycle.
                        taken_c = bus.br_valid & cond_met(bus.br_ccc, flag_q);
                        state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            assign bus.hazard   = hazard_c;
            assign bus.br_taken = taken_c;
        end
    endgenerate

endmodule

// File: doc/flag_ctrl.md
FLAG_CTRL -- requirements
Module: flag_ctrl

Interface
REQ-001 Parameter FORWARD, default 0: 0 = stall branch one cycle on flag hazard; 1 = bypass EX flags to branch evaluation with no stall.
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ex_valid  input  1  EX-stage instruction valid.
REQ-005 ex_opcode  input  4  EX-stage opcode: 0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB, 1000-1111 non-ALU.
REQ-006 alu_z, alu_n, alu_v  input  1 each  combinational ALU flag results for the EX instruction.
REQ-007 stall  input  1  pipeline hold; EX instruction not retiring this cycle.
REQ-008 flush  input  1  EX instruction squashed this cycle.
REQ-009 br_valid  input  1  ID-stage conditional branch (B or BR) present.
REQ-010 br_ccc  input  3  branch condition code.
REQ-011 br_taken  output  1  branch condition result, valid when br_valid and not hazard.
REQ-012 hazard  output  1  request ID stall one cycle (FORWARD=0 only).
REQ-013 flags  output  3  architectural {Z,V,N}, registered.

Function
REQ-014 Flag-write enable fw = ex_valid & ~stall & ~flush.
REQ-015 ADD, SUB with fw: Z, N, V all register from alu_z/alu_n/alu_v at clock edge.
REQ-016 XOR, SLL, SRA, ROR with fw: only Z updates; N, V hold.
REQ-017 RED, PADDSB, all opcodes >= 1000: no flag change.
REQ-018 A flag-setting EX op is "pending" when ex_valid & ~flush and opcode is ADD/SUB/XOR/SLL/SRA/ROR.
REQ-019 Condition evaluation on flag set F: 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&N=0; 011 LT N=1; 100 GTE Z=1|N=0; 101 LTE Z=1|N=1; 110 OV V=1; 111 always.
REQ-020 FORWARD=1: F = registered flags with the bits the pending op would write replaced by alu_* values; hazard tied 0; br_taken fully combinational.
REQ-021 FORWARD=0: two-state FSM IDLE/WAIT; default IDLE.
REQ-022 IDLE: br_valid & pending & ~stall -> hazard=1, br_taken=0, next WAIT.
REQ-023 IDLE: br_valid & ~pending -> hazard=0, br_taken from registered flags, stay IDLE.
REQ-024 WAIT: hazard=0, br_taken from registered flags (now updated), next IDLE unconditionally.
REQ-025 WAIT is never entered twice consecutively; a branch stalls at most one cycle per hazard.
REQ-026 stall=1 in IDLE with pending op: no hazard raised, no flag write, state holds IDLE.
REQ-027 flush=1 of the pending op: op not pending, no hazard, no flag write.
REQ-028 br_valid=0: br_taken=0, hazard=0.
REQ-029 br_taken and hazard are combinational from state, flags and inputs; flags change only at clock edges.

Reset
REQ-030 rst_n low asynchronously forces flags=000, FSM=IDLE, hazard=0 immediately, independent of clk.
REQ-031 Reset asserted while in WAIT returns to IDLE; the deferred branch is discarded.
REQ-032 First edge after rst_n deassertion behaves as IDLE with flags=000.

Verification
REQ-033 SUB producing alu_z=1,alu_n=0,alu_v=0, fw=1 -> next cycle flags=100; XOR with alu_z=0,alu_n=1 next -> flags=000 (N held 0).
REQ-034 FORWARD=0, flags=000, ADD pending with alu_z=1 and br_valid,br_ccc=001 -> cycle0 hazard=1,br_taken=0; cycle1 hazard=0,br_taken=1, flags=100.
REQ-035 FORWARD=1, same stimulus as REQ-034 -> hazard=0, br_taken=1 in cycle0.
REQ-036 ADD with alu_v=1 and flush=1 -> flags unchanged 000; branch ccc=110 -> br_taken=0, no hazard.
REQ-037 Sweep all 8 ccc codes against all 8 registered flag values with no pending op -> br_taken matches REQ-019 table.
REQ-038 Assert rst_n=0 mid-cycle while in WAIT with flags=110 -> flags=000, hazard=0 before next edge; following branch ccc=111 -> br_taken=1.
